// File: rtl/flip_flop_pipe_if.sv
// rtl/flip_flop_pipe_if.sv - control, data and edge-flag bundle for flip_flop_pipe
//
// Purpose: groups the per-cycle controls (en, clr), the data input (d) and the
//          registered outputs (q, q_rise, q_fall, q_chg) of one pipeline.
// Signals:
//   en      1      clock enable: 1 advances the pipeline, 0 holds every stage
//   clr     1      synchronous clear to RST_VAL, active-high, ignores en
//   d       WIDTH  data into stage 0
//   q       WIDTH  final-stage register value
//   q_rise  WIDTH  per-bit 0->1 on the last enabled update
//   q_fall  WIDTH  per-bit 1->0 on the last enabled update
//   q_chg   1      OR-reduction of q_rise | q_fall
// Modports: master drives en/clr/d; slave (the pipeline) drives the outputs.

interface flip_flop_pipe_if #(
    parameter int WIDTH = 1
);
    logic             en;
    logic             clr;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_rise;
    logic [WIDTH-1:0] q_fall;
    logic             q_chg;

    modport master (
        output en,
        output clr,
        output d,
        input  q,
        input  q_rise,
        input  q_fall,
        input  q_chg
    );

    modport slave (
        input  en,
        input  clr,
        input  d,
        output q,
        output q_rise,
        output q_fall,
        output q_chg
    );
endinterface

// File: rtl/flip_flop_pipe.sv
// rtl/flip_flop_pipe.sv - parameterised D flip-flop pipeline with enable, clear and edge flags
//
// Purpose: delays a WIDTH-bit value through STAGES cascaded registers. The
//          final stage is also compared with its previous value to produce
//          one-cycle registered rise/fall flags per bit.
// Parameters:
//   WIDTH    1..64  width of d/q and the edge flags
//   STAGES   1..16  number of register stages (d-to-q latency in enabled edges)
//   RST_VAL         value loaded into every stage on reset or clear
// Ports:
//   clk     input   clock, every state update on the rising edge
//   rst_n   input   synchronous reset, asserted HIGH despite its name
//   bus     slave   en/clr/d in, q/q_rise/q_fall/q_chg out (flip_flop_pipe_if)

module flip_flop_pipe #(
    parameter int               WIDTH   = 1,
    parameter int               STAGES  = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    flip_flop_pipe_if.slave bus
);

    logic [WIDTH-1:0] stage    [STAGES];
    logic [WIDTH-1:0] stage_in [STAGES];
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] last_q;
    logic [WIDTH-1:0] last_next;
    logic             wipe;

    // Next value of each stage when the pipeline advances. Building this as a
    // separate array keeps STAGES=1 legal (no stage[-1] reference anywhere).
    assign stage_in[0] = bus.d;
    for (genvar i = 1; i < STAGES; i++) begin : g_chain
        assign stage_in[i] = stage[i-1];
    end

    assign last_q    = stage[STAGES-1];
    assign last_next = stage_in[STAGES-1];

    // rst_n is active-high; reset and clear share one path, reset just wins
    // by being evaluated together with clear before the enable.
    assign wipe = rst_n || bus.clr;

    always_ff @(posedge clk) begin
        if (wipe) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= RST_VAL;
            end
            prev   <= RST_VAL;
            rise_q <= '0;
            fall_q <= '0;
        end else if (bus.en) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= stage_in[i];
            end
            prev   <= last_q;
            rise_q <= last_next & ~last_q;
            fall_q <= ~last_next & last_q;
        end else begin
            // Holding stages: flags drop so every pulse lasts exactly one cycle.
            rise_q <= '0;
            fall_q <= '0;
        end
    end

    assign bus.q      = last_q;
    assign bus.q_rise = rise_q;
    assign bus.q_fall = fall_q;
    assign bus.q_chg  = |(rise_q | fall_q);

    // prev holds the final stage before its last update, so a raised flag must
    // always agree with the (prev -> q) transition currently in the flops.
    a_rise_consistent : assert property (@(posedge clk) disable iff (rst_n)
        ((rise_q & ~(last_q & ~prev)) == '0));
    a_fall_consistent : assert property (@(posedge clk) disable iff (rst_n)
        ((fall_q & ~(~last_q & prev)) == '0));

endmodule

// File: tb/tb_flip_flop_pipe.sv
// tb/tb_flip_flop_pipe.sv - scoreboard bench for a 1x1 and an 8x3 flip_flop_pipe

module tb_flip_flop_pipe;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       chg;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;
    int   tests_run = 0;
    int   tests_failed = 0;
    obs_t sb1[$];
    obs_t sb8[$];

    flip_flop_pipe_if #(.WIDTH(1)) bus1 ();
    flip_flop_pipe_if #(.WIDTH(8)) bus8 ();

    flip_flop_pipe #(.WIDTH(1), .STAGES(1), .RST_VAL(1'b0)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    flip_flop_pipe #(.WIDTH(8), .STAGES(3), .RST_VAL(8'h00)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(input logic [7:0] q, input logic [7:0] r, input logic [7:0] f);
        obs_t o;
        o.q = q; o.rise = r; o.fall = f; o.chg = |(r | f);
        return o;
    endfunction

    function automatic obs_t got1();
        return mk({7'd0, bus1.q}, {7'd0, bus1.q_rise}, {7'd0, bus1.q_fall}) ^ {25'd0, (bus1.q_chg ^ |(bus1.q_rise | bus1.q_fall))};
    endfunction

    function automatic obs_t got8();
        obs_t o;
        o.q = bus8.q; o.rise = bus8.q_rise; o.fall = bus8.q_fall; o.chg = bus8.q_chg;
        return o;
    endfunction

    // Drive both pipelines on the falling edge, then sample 1 ns after the rise.
    task automatic tick(input logic rst, input logic en1, input logic clr1, input logic d1,
                        input logic en8, input logic clr8, input logic [7:0] d8);
        @(negedge clk);
        rst_n = rst;
        bus1.en = en1; bus1.clr = clr1; bus1.d = d1;
        bus8.en = en8; bus8.clr = clr8; bus8.d = d8;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t e, g;
        tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF);
        tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF);
        sb1.push_back(mk(8'h00, 8'h00, 8'h00));
        sb8.push_back(mk(8'h00, 8'h00, 8'h00));
        e = sb1.pop_front(); g = got1(); tests_run++;
        if (g !== e) begin tests_failed++; $display("FAIL reset_1x1 got=%h exp=%h", g, e); end
        e = sb8.pop_front(); g = got8(); tests_run++;
        if (g !== e) begin tests_failed++; $display("FAIL reset_8x3 got=%h exp=%h", g, e); end
    endtask

    task automatic test_basic_dff();
        obs_t e, g;
        logic [2:0] dv = 3'b101;
        sb1.push_back(mk(8'h01, 8'h01, 8'h00));
        sb1.push_back(mk(8'h00, 8'h00, 8'h01));
        sb1.push_back(mk(8'h01, 8'h01, 8'h00));
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, 1'b0, dv[2-i], 1'b0, 1'b0, 8'h00);
            e = sb1.pop_front(); g = got1(); tests_run++;
            if (g !== e) begin tests_failed++; $display("FAIL basic_dff[%0d] got=%h exp=%h", i, g, e); end
        end
        // Pipeline held: the rise flag from the last update must drop.
        sb1.push_back(mk(8'h01, 8'h00, 8'h00));
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        e = sb1.pop_front(); g = got1(); tests_run++;
        if (g !== e) begin tests_failed++; $display("FAIL basic_hold got=%h exp=%h", g, e); end
    endtask

    task automatic test_latency();
        obs_t e, g;
        logic [7:0] dv [5] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
        sb8.push_back(mk(8'h00, 8'h00, 8'h00));
        sb8.push_back(mk(8'h00, 8'h00, 8'h00));
        sb8.push_back(mk(8'hA5, 8'hA5, 8'h00));
        sb8.push_back(mk(8'h00, 8'h00, 8'hA5));
        sb8.push_back(mk(8'h00, 8'h00, 8'h00));
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, dv[i]);
            e = sb8.pop_front(); g = got8(); tests_run++;
            if (g !== e) begin tests_failed++; $display("FAIL latency[%0d] got=%h exp=%h", i, g, e); end
        end
    endtask

    task automatic test_enable_hold();
        obs_t e, g;
        logic [7:0] dv [10] = '{8'h11, 8'h22, 8'h33, 8'h99, 8'h99, 8'h99, 8'h99, 8'h00, 8'h00, 8'h00};
        logic       ev [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        sb8.push_back(mk(8'h00, 8'h00, 8'h00));
        sb8.push_back(mk(8'h00, 8'h00, 8'h00));
        sb8.push_back(mk(8'h11, 8'h11, 8'h00));
        for (int i = 0; i < 4; i++) sb8.push_back(mk(8'h11, 8'h00, 8'h00));
        sb8.push_back(mk(8'h22, 8'h22, 8'h11));
        sb8.push_back(mk(8'h33, 8'h11, 8'h00));
        sb8.push_back(mk(8'h00, 8'h00, 8'h33));
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0, ev[i], 1'b0, dv[i]);
            e = sb8.pop_front(); g = got8(); tests_run++;
            if (g !== e) begin tests_failed++; $display("FAIL enable_hold[%0d] got=%h exp=%h", i, g, e); end
        end
    endtask

    task automatic test_clear();
        obs_t e, g;
        sb8.push_back(mk(8'h00, 8'h00, 8'h00));
        sb8.push_back(mk(8'h00, 8'h00, 8'h00));
        sb8.push_back(mk(8'hFF, 8'hFF, 8'h00));
        sb8.push_back(mk(8'hFF, 8'h00, 8'h00));
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF);
            e = sb8.pop_front(); g = got8(); tests_run++;
            if (g !== e) begin tests_failed++; $display("FAIL clear_fill[%0d] got=%h exp=%h", i, g, e); end
        end
        // Clear with en low on both pipelines; the 1x1 one still holds q=1.
        sb8.push_back(mk(8'h00, 8'h00, 8'h00));
        sb1.push_back(mk(8'h00, 8'h00, 8'h00));
        tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF);
        e = sb8.pop_front(); g = got8(); tests_run++;
        if (g !== e) begin tests_failed++; $display("FAIL clear_8x3 got=%h exp=%h", g, e); end
        e = sb1.pop_front(); g = got1(); tests_run++;
        if (g !== e) begin tests_failed++; $display("FAIL clear_1x1 got=%h exp=%h", g, e); end
        sb8.push_back(mk(8'h00, 8'h00, 8'h00));
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A);
        e = sb8.pop_front(); g = got8(); tests_run++;
        if (g !== e) begin tests_failed++; $display("FAIL clear_after got=%h exp=%h", g, e); end
    endtask

    task automatic test_reset_priority();
        obs_t e, g;
        // Stage 0 holds 0x5A here; reset with en=1 must wipe it, so 0x5A never reaches q.
        sb8.push_back(mk(8'h00, 8'h00, 8'h00));
        tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hC3);
        e = sb8.pop_front(); g = got8(); tests_run++;
        if (g !== e) begin tests_failed++; $display("FAIL rst_priority got=%h exp=%h", g, e); end
        sb8.push_back(mk(8'h00, 8'h00, 8'h00));
        sb8.push_back(mk(8'h00, 8'h00, 8'h00));
        sb8.push_back(mk(8'hC3, 8'hC3, 8'h00));
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hC3);
            e = sb8.pop_front(); g = got8(); tests_run++;
            if (g !== e) begin tests_failed++; $display("FAIL rst_refill[%0d] got=%h exp=%h", i, g, e); end
        end
    endtask

    task automatic test_reset_midstream();
        obs_t e, g;
        logic [7:0] dv [6] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
        logic       rv [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        sb8.push_back(mk(8'hC3, 8'h00, 8'h00));
        sb8.push_back(mk(8'hC3, 8'h00, 8'h00));
        sb8.push_back(mk(8'h00, 8'h00, 8'h00));
        sb8.push_back(mk(8'h00, 8'h00, 8'h00));
        sb8.push_back(mk(8'h00, 8'h00, 8'h00));
        sb8.push_back(mk(8'h40, 8'h40, 8'h00));
        for (int i = 0; i < 6; i++) begin
            tick(rv[i], 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, dv[i]);
            e = sb8.pop_front(); g = got8(); tests_run++;
            if (g !== e) begin tests_failed++; $display("FAIL rst_midstream[%0d] got=%h exp=%h", i, g, e); end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        bus1.en = 1'b1; bus1.clr = 1'b0; bus1.d = 1'b1;
        bus8.en = 1'b1; bus8.clr = 1'b0; bus8.d = 8'hFF;
        test_reset();
        test_basic_dff();
        test_latency();
        test_enable_hold();
        test_clear();
        test_reset_priority();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
